// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared FSM state encoding and default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Request/result bundle between a requester and the subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout
    );

endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full-subtractor cell (difference and borrow-out).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic x,
    input  wire logic y,
    input  wire logic bi,
    output logic      d,
    output logic      bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_bout;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_d;
    logic               w_bo;

    full_subtractor u_cell (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last = (r_cnt == c_last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Difference bits enter at the top of r_a as minuend bits leave the
    // bottom, so after WIDTH shifts r_a holds the full result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a_in;
            r_b      <= bus.b_in;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= {w_d, r_a[WIDTH-1:1]};
            r_b      <= r_b >> 1;
            r_borrow <= w_bo;
            r_cnt    <= r_cnt + c_cnt_one;
            if (w_last) begin
                r_diff <= {w_d, r_a[WIDTH-1:1]};
                r_bout <= w_bo;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and back-to-back random checks with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi);
        exp_t e;
        int   r;
        r      = int'(a) - int'(b) - int'(bi);
        e.diff = r[WIDTH-1:0];
        e.bout = (int'(a) < (int'(b) + int'(bi)));
        return e;
    endfunction

    // Every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            check("sb_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("bout", 32'(bus.bout), 32'(e.bout));
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.bin   = bi;
    endtask

    // Caller is at a negedge; runs one isolated operation and checks latency.
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        int cyc;
        drive(a, b, bi);
        q.push_back(model(a, b, bi));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_shift", 32'(bus.busy), 32'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(WIDTH + 1));
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int done_before;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.bin   = 1'b0;

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, the first one issued right after reset release
        op(4'd9, 4'd3, 1'b0);
        op(4'd3, 4'd9, 1'b0);
        op(4'd0, 4'd0, 1'b1);
        op(4'hF, 4'hF, 1'b1);
        op(4'hF, 4'h0, 1'b0);

        // Start while busy must be ignored
        done_before = n_done;
        drive(4'd5, 4'd2, 1'b0);
        q.push_back(model(4'd5, 4'd2, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(4'd1, 4'd7, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("one_done_pulse", 32'(n_done - done_before), 32'd1);

        // Reset in the second SHIFT cycle aborts with no done
        done_before = n_done;
        drive(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(n_done - done_before), 32'd0);

        // Back-to-back with start held high
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             bi;
            a  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            b  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            bi = 1'($urandom_range(0, 1));
            drive(a, b, bi);
            q.push_back(model(a, b, bi));
            repeat (WIDTH + 1) @(negedge clk);
            check("b2b_done", 32'(bus.done), 32'd1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
